// File: rtl/inert_sensor_resp_pkg.sv
// Shared definitions for the inertial sensor responder: register
// addresses, frame FSM encoding and command field positions.
package inert_pkg;

    // Register addresses (7-bit)
    localparam logic [6:0] INT1_CTRL = 7'h0D;
    localparam logic [6:0] CTRL1_XL  = 7'h10;
    localparam logic [6:0] CTRL2_G   = 7'h11;
    localparam logic [6:0] CTRL3     = 7'h14;
    localparam logic [6:0] STATUS    = 7'h1E;
    localparam logic [6:0] OUTX_L_G  = 7'h22;
    localparam logic [6:0] OUTX_H_G  = 7'h23;
    localparam logic [6:0] OUTZ_L_XL = 7'h2C;
    localparam logic [6:0] OUTZ_H_XL = 7'h2D;

    // INT1_CTRL value that routes data-ready to INT
    localparam logic [7:0] INT1_DRDY = 8'h02;

    // 16-bit command frame, MSB first: {R/W, addr[6:0], data[7:0]}
    localparam int unsigned CMD_RW_BIT   = 15;
    localparam int unsigned CMD_ADDR_LSB = 8;
    localparam int unsigned CMD_ADDR_W   = 7;
    localparam int unsigned CMD_DATA_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        CMPLT
    } frm_state_t;

endpackage

// File: rtl/inert_sensor_resp_spi_slv16.sv
// 16-bit SPI slave front end: input synchronizers, edge detection,
// frame FSM, receive/transmit shift registers. Emits a read-data fetch
// at the 8th SCLK rise and commit/abort pulses on SS_n rise.
module spi_slv16
    import inert_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SS_n,
    input  logic                  SCLK,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  busy,
    output logic                  rdata_req,
    output logic [CMD_ADDR_W-1:0] req_addr,
    input  logic [CMD_DATA_W-1:0] rdata,
    output logic [CMD_ADDR_W-1:0] addr,
    output logic                  is_rd,
    output logic [CMD_DATA_W-1:0] wdata,
    output logic                  commit,
    output logic                  abort
);

    frm_state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
    logic                   ss_d, sclk_d;
    logic                   ss_s, sclk_s, mosi_s;
    logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [3:0]             rise_cnt;
    logic [6:0]             rx;
    logic [7:0]             rx_byte;
    logic [7:0]             tx;
    logic                   last_hdr_rise, last_data_rise;

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign ss_fall   = ~ss_s & ss_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    // MOSI passes the same number of stages as SCLK, so mosi_s is the bit
    // that was on the wire when the detected rise occurred.
    assign rx_byte  = {rx, mosi_s};
    assign req_addr = rx_byte[CMD_ADDR_W-1:0];

    assign last_hdr_rise  = sclk_rise && (rise_cnt == 4'd7);
    assign last_data_rise = sclk_rise && (rise_cnt == 4'd15);

    // Synchronizers and edge-detect history; idle levels are SS_n=1, SCLK=1
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync   <= '1;
            sclk_sync <= '1;
            mosi_sync <= '0;
            ss_d      <= 1'b1;
            sclk_d    <= 1'b1;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_d      <= ss_s;
            sclk_d    <= sclk_s;
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Frame FSM next-state; an SS_n rise before the 16th bit aborts
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = ADDR;
            ADDR: begin
                if (ss_rise)            state_nxt = IDLE;
                else if (last_hdr_rise) state_nxt = DATA;
            end
            DATA: begin
                if (ss_rise)             state_nxt = IDLE;
                else if (last_data_rise) state_nxt = CMPLT;
            end
            CMPLT:   if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame FSM outputs: status, read fetch and end-of-frame pulses
    always_comb begin
        busy      = (state != IDLE);
        commit    = (state == CMPLT) && ss_rise;
        abort     = ((state == ADDR) || (state == DATA)) && ss_rise;
        rdata_req = (state == ADDR) && last_hdr_rise && !ss_rise;
    end

    // Receive shift register, bit counter and latched command fields
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_cnt <= '0;
            rx       <= '0;
            is_rd    <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
        end else begin
            if ((state == IDLE) && ss_fall) begin
                rise_cnt <= '0;
                rx       <= '0;
            end else if (((state == ADDR) || (state == DATA)) && sclk_rise) begin
                rise_cnt <= rise_cnt + 4'd1;
                rx       <= rx_byte[6:0];
            end
            if (rdata_req) begin
                is_rd <= rx_byte[CMD_RW_BIT-CMD_ADDR_LSB];
                addr  <= rx_byte[CMD_ADDR_W-1:0];
            end
            if ((state == DATA) && last_data_rise && !ss_rise)
                wdata <= rx_byte[CMD_DATA_W-1:0];
        end
    end

    // Transmit shift register, loaded once per frame at the 8th rise
    always_ff @(posedge clk) begin
        if (rst)                                tx <= '0;
        else if (rdata_req)                     tx <= rdata;
        else if ((state == DATA) && sclk_fall)  tx <= {tx[6:0], 1'b0};
    end

    // MISO: 1 when idle, 0 through the header, data bits change on falls
    always_ff @(posedge clk) begin
        if (rst)                               MISO <= 1'b1;
        else if (state_nxt == IDLE)            MISO <= 1'b1;
        else if (state == IDLE)                MISO <= 1'b0;
        else if ((state == DATA) && sclk_fall) MISO <= tx[7];
    end

endmodule

// File: rtl/inert_sensor_resp.sv
// Inertial sensor responder (SPI slave model) for the Segway bench.
// Holds the configuration registers, the sample timer, the latched
// pitch-rate / Z-accel data and the INT flag.
// Optional: define INERT_STATUS_REG_EN to add the STATUS register (0x1E)
// with XLDA (bit0) and GDA (bit1) data-available flags.
module inert_sensor_resp
    import inert_pkg::*;
#(
    parameter int unsigned SAMPLE_CYCLES = 240385,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic [15:0] ptch_rt_in,
    input  logic [15:0] az_in,
    output logic        stream_en
);

    localparam int unsigned TMR_W = $clog2(SAMPLE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_CYCLES - 1);

    logic                  busy, rdata_req, is_rd, commit, abort;
    logic [CMD_ADDR_W-1:0] req_addr, addr;
    logic [CMD_DATA_W-1:0] rdata, wdata;

    logic [7:0]       int1_ctrl, ctrl1_xl, ctrl2_g, ctrl3;
    logic [15:0]      ptch_rt, az;
    logic             int_flag, pend;
    logic [TMR_W-1:0] timer;
    logic             sample_evt, apply, wr_commit, rd_commit, stop;

    spi_slv16 #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_spi (
        .clk       (clk),
        .rst       (rst),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .busy      (busy),
        .rdata_req (rdata_req),
        .req_addr  (req_addr),
        .rdata     (rdata),
        .addr      (addr),
        .is_rd     (is_rd),
        .wdata     (wdata),
        .commit    (commit),
        .abort     (abort)
    );

    assign stream_en = (int1_ctrl == INT1_DRDY) && (|ctrl1_xl) && (|ctrl2_g);
    assign INT       = int_flag;

    assign wr_commit  = commit && !is_rd;
    assign rd_commit  = commit && is_rd;
    assign stop       = wr_commit && (addr == INT1_CTRL) && !wdata[1];
    assign sample_evt = stream_en && (timer == TMR_LAST);

    // A sample taken mid-frame is deferred to the frame's end so a read
    // never sees half-old, half-new data. Disabling the stream drops it.
    assign apply = (sample_evt || pend) && (!busy || commit || abort) && !stop;

    // Configuration registers, updated at write commit
    always_ff @(posedge clk) begin
        if (rst) begin
            int1_ctrl <= '0;
            ctrl1_xl  <= '0;
            ctrl2_g   <= '0;
            ctrl3     <= '0;
        end else if (wr_commit) begin
            case (addr)
                INT1_CTRL: int1_ctrl <= wdata;
                CTRL1_XL:  ctrl1_xl  <= wdata;
                CTRL2_G:   ctrl2_g   <= wdata;
                CTRL3:     ctrl3     <= wdata;
                default:   ;
            endcase
        end
    end

    // Sample timer: free-runs only while streaming
    always_ff @(posedge clk) begin
        if (rst || !stream_en || stop) timer <= '0;
        else if (timer == TMR_LAST)    timer <= '0;
        else                           timer <= timer + 1'b1;
    end

    // Pending-sample flag and latched sample data
    always_ff @(posedge clk) begin
        if (rst) begin
            pend    <= 1'b0;
            ptch_rt <= '0;
            az      <= '0;
        end else begin
            if (stop || apply) pend <= 1'b0;
            else if (sample_evt) pend <= 1'b1;
            if (apply) begin
                ptch_rt <= ptch_rt_in;
                az      <= az_in;
            end
        end
    end

    // INT: set by an applied sample (wins over the 0x2D read clear)
    always_ff @(posedge clk) begin
        if (rst || stop)                               int_flag <= 1'b0;
        else if (apply)                                int_flag <= 1'b1;
        else if (rd_commit && (addr == OUTZ_H_XL))     int_flag <= 1'b0;
    end

`ifdef INERT_STATUS_REG_EN
    logic xlda, gda;

    // Data-available flags: set by an applied sample, cleared by high-byte reads
    always_ff @(posedge clk) begin
        if (rst) begin
            xlda <= 1'b0;
            gda  <= 1'b0;
        end else begin
            if (apply)                                  xlda <= 1'b1;
            else if (rd_commit && (addr == OUTZ_H_XL))  xlda <= 1'b0;
            if (apply)                                  gda  <= 1'b1;
            else if (rd_commit && (addr == OUTX_H_G))   gda  <= 1'b0;
        end
    end
`endif

    // Read-data mux, sampled by the slave at the 8th SCLK rise
    always_comb begin
        rdata = '0;
        if (rdata_req) begin
            case (req_addr)
                INT1_CTRL: rdata = int1_ctrl;
                CTRL1_XL:  rdata = ctrl1_xl;
                CTRL2_G:   rdata = ctrl2_g;
                CTRL3:     rdata = ctrl3;
`ifdef INERT_STATUS_REG_EN
                STATUS:    rdata = {6'b0, gda, xlda};
`endif
                OUTX_L_G:  rdata = ptch_rt[7:0];
                OUTX_H_G:  rdata = ptch_rt[15:8];
                OUTZ_L_XL: rdata = az[7:0];
                OUTZ_H_XL: rdata = az[15:8];
                default:   rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_inert_sensor_resp.sv
// Directed self-checking bench for inert_sensor_resp (SAMPLE_CYCLES=1000
// so a full SPI frame fits well inside one sample period).
module tb_inert_sensor_resp;

    localparam int unsigned SC = 1000;

    logic        clk = 1'b0;
    logic        rst, SS_n, SCLK, MOSI;
    logic        MISO, INT, stream_en;
    logic [15:0] ptch_rt_in, az_in;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inert_sensor_resp #(
        .SAMPLE_CYCLES(SC),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SS_n       (SS_n),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .INT        (INT),
        .ptch_rt_in (ptch_rt_in),
        .az_in      (az_in),
        .stream_en  (stream_en)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI transfer: 8 clk per SCLK half period, MISO sampled just before each rise
    task automatic xfer(input logic [15:0] cmd, input int nrise, input bit release_ss,
                        output logic [7:0] rd);
        rd = '0;
        tick(8);
        SS_n = 1'b0;
        tick(8);
        for (int i = 0; i < nrise; i++) begin
            SCLK = 1'b0;
            MOSI = cmd[15-i];
            tick(8);
            if (i >= 8) rd = {rd[6:0], MISO};
            SCLK = 1'b1;
            tick(8);
        end
        if (release_ss) SS_n = 1'b1;
    endtask

    task automatic frame(input logic [15:0] cmd, output logic [7:0] rd);
        xfer(cmd, 16, 1'b1, rd);
        tick(4);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rd;
        logic [7:0] exp_status;
        int n;

`ifdef INERT_STATUS_REG_EN
        exp_status = 8'h03;
`else
        exp_status = 8'h00;
`endif
        rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        ptch_rt_in = 16'h1234; az_in = 16'hABCD;
        tick(4);
        check_eq("rst_miso", MISO, 1);
        check_eq("rst_int", INT, 0);
        check_eq("rst_stream_en", stream_en, 0);
        rst = 1'b0;
        tick(2);

        // boot configuration; streaming needs all three of 0x0D, 0x10, 0x11
        frame(16'h1460, rd);
        frame(16'h0D02, rd);
        frame(16'h1053, rd);
        check_eq("se_partial_cfg", stream_en, 0);
        frame(16'h9400, rd); check_eq("rd_ctrl3", rd, 8'h60);
        frame(16'h9000, rd); check_eq("rd_ctrl1", rd, 8'h53);
        frame(16'h8D00, rd); check_eq("rd_int1", rd, 8'h02);
        check_eq("int_before_sample", INT, 0);

        xfer(16'h1150, 16, 1'b1, rd);
        n = 0;
        while (!stream_en && n < 20) begin @(posedge clk); #1; n++; end
        check_eq("se_rise", stream_en, 1);
        n = 0;
        while (!INT && n < 2*SC) begin @(posedge clk); #1; n++; end
        check_eq("int_latency", n, SC);

        // next sample is SC cycles after this point
        frame(16'hAD00, rd); check_eq("rd_az_h", rd, 8'hAB);
        check_eq("int_clr_2d", INT, 0);
        frame(16'hA200, rd); check_eq("rd_pr_l", rd, 8'h34);
        frame(16'hA300, rd); check_eq("rd_pr_h", rd, 8'h12);
        ptch_rt_in = 16'h5678; az_in = 16'h9ABC;
        xfer(16'hAC00, 16, 1'b0, rd);
        check_eq("rd_az_l_old", rd, 8'hCD);
        check_eq("int_deferred", INT, 0);
        SS_n = 1'b1;
        tick(4);
        check_eq("int_at_commit", INT, 1);
        frame(16'h9E00, rd); check_eq("rd_status", rd, exp_status);
        frame(16'hA200, rd); check_eq("rd_pr_l_new", rd, 8'h78);
        frame(16'hAD00, rd); check_eq("rd_az_h_new", rd, 8'h9A);
        check_eq("int_clr_2d_b", INT, 0);

        // read-only and unmapped accesses
        frame(16'h2255, rd);
        frame(16'hA200, rd); check_eq("ro_write_ignored", rd, 8'h78);
        frame(16'h8F00, rd); check_eq("rd_unmapped", rd, 8'h00);

        // aborted write after 10 rises, then full frames
        xfer(16'h1000, 10, 1'b1, rd);
        tick(4);
        frame(16'h9000, rd); check_eq("abort_no_write", rd, 8'h53);
        frame(16'h1077, rd);
        frame(16'h9000, rd); check_eq("write_after_abort", rd, 8'h77);
        check_eq("se_after_abort", stream_en, 1);

        // stream disable clears INT
        n = 0;
        while (!INT && n < 2*SC) begin @(posedge clk); #1; n++; end
        check_eq("int_resample", INT, 1);
        frame(16'h0D00, rd);
        check_eq("int_clr_disable", INT, 0);
        check_eq("se_disable", stream_en, 0);
        frame(16'h0D02, rd);
        check_eq("se_reenable", stream_en, 1);
        n = 0;
        while (!INT && n < 2*SC) begin @(posedge clk); #1; n++; end
        check_eq("int_restart", INT, 1);

        // reset at rise 12 of a read
        xfer(16'hAD00, 12, 1'b0, rd);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_eq("rstmid_miso", MISO, 1);
        check_eq("rstmid_int", INT, 0);
        check_eq("rstmid_se", stream_en, 0);
        SS_n = 1'b1;
        tick(8);
        check_eq("rstmid_miso_idle", MISO, 1);
        frame(16'h9000, rd); check_eq("rstmid_ctrl1", rd, 8'h00);
        frame(16'h9100, rd); check_eq("rstmid_ctrl2", rd, 8'h00);
        frame(16'h9400, rd); check_eq("rstmid_ctrl3", rd, 8'h00);
        frame(16'h8D00, rd); check_eq("rstmid_int1", rd, 8'h00);
        frame(16'hA200, rd); check_eq("rstmid_pr_l", rd, 8'h00);
        frame(16'hAD00, rd); check_eq("rstmid_az_h", rd, 8'h00);
        frame(16'h1455, rd);
        frame(16'h9400, rd); check_eq("post_rst_frame", rd, 8'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
